gf16_matmul: RTL and testbench

GF16_MATMUL -- requirements
Module: gf16_matmul

---
 rtl/gfmm_pkg.sv | 17 +
 rtl/gf16_mul.sv | 29 ++
 rtl/gf16_matmul.sv | 131 +++++++++++++
 tb/tb_gf16_matmul.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/gfmm_pkg.sv
// rtl/gfmm_pkg.sv - shared types and constants for the GF(2^4) 2x2 matrix multiplier
package gfmm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_t;

  // x^4 + x + 1
  localparam logic [4:0] GF_POLY   = 5'h13;
  localparam int         NUM_TERMS = 8;
  localparam int         K_W       = $clog2(NUM_TERMS);

  typedef logic [3:0] gf_elem_t;

endpackage

// File: rtl/gf16_mul.sv
// rtl/gf16_mul.sv - combinational GF(2^4) multiplier, reduced by GF_POLY
// Ports:
//   a, b : in  4-bit field elements
//   p    : out 4-bit product a*b mod GF_POLY
module gf16_mul
  import gfmm_pkg::*;
(
  input  gf_elem_t a,
  input  gf_elem_t b,
  output gf_elem_t p
);

  logic [6:0] clmul;
  logic [6:0] red;

  always_comb begin
    clmul = '0;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) clmul = clmul ^ ({3'b000, a} << i);
    end
    // Fold the high terms down from the top so each step clears one bit.
    red = clmul;
    for (int i = 6; i >= 4; i--) begin
      if (red[i]) red = red ^ ({2'b00, GF_POLY} << (i - 4));
    end
    p = red[3:0];
  end

endmodule

// File: rtl/gf16_matmul.sv
// rtl/gf16_matmul.sv - sequential 2x2 matrix product over GF(2^4), one term per cycle
// Ports:
//   clk               : in  system clock, rising edge
//   RST               : in  asynchronous active-high reset
//   math_time         : in  start request
//   A00..A11, B00..B11: in  operand matrices, captured on an accepted start
//   C00..C11          : out registered product C = A x B, held until next valid
//   busy              : out high while the FSM is not IDLE
//   valid             : out one-cycle pulse when C is updated
//   err               : out one-cycle pulse when a start is rejected while busy
//   Cpar              : out XOR of all C bits (only with GFMM_PARITY_EN defined)
module gf16_matmul
  import gfmm_pkg::*;
(
  input  logic       clk,
  input  logic       RST,
  input  logic       math_time,
  input  logic [3:0] A00,
  input  logic [3:0] A01,
  input  logic [3:0] A10,
  input  logic [3:0] A11,
  input  logic [3:0] B00,
  input  logic [3:0] B01,
  input  logic [3:0] B10,
  input  logic [3:0] B11,
  output logic [3:0] C00,
  output logic [3:0] C01,
  output logic [3:0] C10,
  output logic [3:0] C11,
  output logic       busy,
  output logic       valid,
  output logic       err
`ifdef GFMM_PARITY_EN
  ,
  output logic       Cpar
`endif
);

  state_t              state;
  state_t              state_next;
  logic [K_W-1:0]      k;
  gf_elem_t [1:0][1:0] a_q;
  gf_elem_t [1:0][1:0] b_q;
  gf_elem_t [3:0]      acc;
  gf_elem_t            mul_a;
  gf_elem_t            mul_b;
  gf_elem_t            mul_p;

  assign busy = (state != IDLE);

  // Term k: C[k[2]][k[1]] += A[k[2]][k[0]] * B[k[0]][k[1]].
  // The accumulator index is therefore k[2:1] in C00,C01,C10,C11 order.
  assign mul_a = a_q[k[2]][k[0]];
  assign mul_b = b_q[k[0]][k[1]];

  gf16_mul u_mul (
    .a (mul_a),
    .b (mul_b),
    .p (mul_p)
  );

  always_ff @(posedge clk or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (math_time) state_next = MAC;
      MAC:     if (k == K_W'(NUM_TERMS - 1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      k     <= '0;
      a_q   <= '0;
      b_q   <= '0;
      acc   <= '0;
      C00   <= '0;
      C01   <= '0;
      C10   <= '0;
      C11   <= '0;
      valid <= 1'b0;
      err   <= 1'b0;
    end else begin
      valid <= 1'b0;
      // DONE counts as busy, so a start on the result-load edge is rejected too.
      err   <= math_time && (state != IDLE);
      case (state)
        IDLE: begin
          if (math_time) begin
            a_q[0][0] <= A00;
            a_q[0][1] <= A01;
            a_q[1][0] <= A10;
            a_q[1][1] <= A11;
            b_q[0][0] <= B00;
            b_q[0][1] <= B01;
            b_q[1][0] <= B10;
            b_q[1][1] <= B11;
            acc       <= '0;
            k         <= '0;
          end
        end
        MAC: begin
          acc[k[2:1]] <= acc[k[2:1]] ^ mul_p;
          k           <= k + 1'b1;
        end
        DONE: begin
          C00   <= acc[0];
          C01   <= acc[1];
          C10   <= acc[2];
          C11   <= acc[3];
          valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef GFMM_PARITY_EN
  always_ff @(posedge clk or posedge RST) begin
    if (RST)                Cpar <= 1'b0;
    else if (state == DONE) Cpar <= ^acc;
  end
`endif

endmodule

// File: tb/tb_gf16_matmul.sv
// tb/tb_gf16_matmul.sv - self-checking bench for gf16_matmul
module tb_gf16_matmul;

  logic       clk = 1'b0;
  logic       RST;
  logic       math_time;
  logic [3:0] A00, A01, A10, A11;
  logic [3:0] B00, B01, B10, B11;
  logic [3:0] C00, C01, C10, C11;
  logic       busy, valid, err;
`ifdef GFMM_PARITY_EN
  logic       Cpar;
`endif

  always #5 clk = ~clk;

  gf16_matmul dut (
    .clk       (clk),
    .RST       (RST),
    .math_time (math_time),
    .A00 (A00), .A01 (A01), .A10 (A10), .A11 (A11),
    .B00 (B00), .B01 (B01), .B10 (B10), .B11 (B11),
    .C00 (C00), .C01 (C01), .C10 (C10), .C11 (C11),
    .busy      (busy),
    .valid     (valid),
    .err       (err)
`ifdef GFMM_PARITY_EN
    ,
    .Cpar      (Cpar)
`endif
  );

  // Matrices packed as {m00, m01, m10, m11}.
  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] c;
  } vec_t;

  vec_t        vecs [8];
  logic [15:0] exp_q [$];
  int          total = 0;
  int          bad = 0;
  int          valid_cnt = 0;
  int          err_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Field multiply by repeated doubling (xtime), reducing every step.
  function automatic logic [3:0] gmul(input logic [3:0] x, input logic [3:0] y);
    logic [3:0] r;
    logic [3:0] p;
    r = 4'h0;
    p = x;
    for (int i = 0; i < 4; i++) begin
      if (y[i]) r = r ^ p;
      p = p[3] ? ({p[2:0], 1'b0} ^ 4'h3) : {p[2:0], 1'b0};
    end
    return r;
  endfunction

  function automatic logic [15:0] matmul(input logic [15:0] a, input logic [15:0] b);
    logic [3:0] c00, c01, c10, c11;
    c00 = gmul(a[15:12], b[15:12]) ^ gmul(a[11:8], b[7:4]);
    c01 = gmul(a[15:12], b[11:8])  ^ gmul(a[11:8], b[3:0]);
    c10 = gmul(a[7:4],   b[15:12]) ^ gmul(a[3:0],  b[7:4]);
    c11 = gmul(a[7:4],   b[11:8])  ^ gmul(a[3:0],  b[3:0]);
    return {c00, c01, c10, c11};
  endfunction

  // Scoreboard: every valid pulse pops one expected result.
  always @(negedge clk) begin
    if (err) err_cnt++;
    if (valid) begin
      valid_cnt++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid actual=%0h required=none", {C00, C01, C10, C11});
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        chk("C", {C00, C01, C10, C11}, e);
`ifdef GFMM_PARITY_EN
        chk("Cpar", Cpar, ^e);
`endif
      end
    end
  end

  task automatic set_ops(input logic [15:0] a, input logic [15:0] b);
    {A00, A01, A10, A11} = a;
    {B00, B01, B10, B11} = b;
  endtask

  // Drives a start so that it is sampled on the next rising edge (E0); returns just after E0.
  task automatic start(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    @(negedge clk);
    set_ops(a, b);
    math_time = 1'b1;
    exp_q.push_back(c);
    @(posedge clk);
    #1 math_time = 1'b0;
  endtask

  // Observes the 10 cycles after E0; mt_at[n] drives math_time into edge E(n+1).
  // Returns just after E10.
  task automatic run_tail(input string tag, input logic [9:0] mt_at, input bit scramble);
    logic [9:0] bv;
    logic [9:0] vv;
    bv = '0;
    vv = '0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      bv[n] = busy;
      vv[n] = valid;
      math_time = mt_at[n];
      if (scramble) set_ops(16'($urandom()), 16'($urandom()));
    end
    @(posedge clk);
    #1 math_time = 1'b0;
    chk({tag, "_busy"}, bv, 10'h1FF);
    chk({tag, "_valid"}, vv, 10'h200);
  endtask

  initial begin
    int          e0;
    int          v0;
    logic [15:0] a2;
    logic [15:0] b2;

    vecs[0] = '{16'h1001, 16'h379F, 16'h379F};
    vecs[1] = '{16'h2002, 16'h8888, 16'h3333};
    vecs[2] = '{16'hF000, 16'hF000, 16'hA000};
    vecs[3] = '{16'h1111, 16'h1111, 16'h0000};
    for (int i = 4; i < 8; i++) begin
      vecs[i].a = 16'($urandom());
      vecs[i].b = 16'($urandom());
      vecs[i].c = matmul(vecs[i].a, vecs[i].b);
    end

    RST = 1'b1;
    math_time = 1'b0;
    set_ops(16'h0, 16'h0);
    repeat (3) @(negedge clk);
    chk("reset_C", {C00, C01, C10, C11}, 16'h0);
    chk("reset_flags", {busy, valid, err}, 3'b000);
`ifdef GFMM_PARITY_EN
    chk("reset_Cpar", Cpar, 1'b0);
`endif
    RST = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      start(vecs[i].a, vecs[i].b, vecs[i].c);
      run_tail($sformatf("vec%0d", i), 10'h000, 1'b0);
    end

    // C holds after the pulse.
    repeat (5) @(negedge clk);
    chk("hold_C", {C00, C01, C10, C11}, vecs[7].c);

    // Operands wiggling during MAC must not leak into the result.
    start(16'hC35A, 16'h9E21, matmul(16'hC35A, 16'h9E21));
    run_tail("scramble", 10'h000, 1'b1);

    // Rejected starts at E4 and E9, accepted start at E10.
    a2 = 16'h1234;
    b2 = 16'h5678;
    e0 = err_cnt;
    start(16'h4D2B, 16'h7A16, matmul(16'h4D2B, 16'h7A16));
    set_ops(a2, b2);
    exp_q.push_back(matmul(a2, b2));
    run_tail("err_run", 10'h308, 1'b0);
    run_tail("e10_run", 10'h000, 1'b0);
    chk("err_pulses", err_cnt - e0, 2);

    // Reset at E5 aborts with no valid.
    start(16'h8421, 16'h1248, matmul(16'h8421, 16'h1248));
    repeat (5) @(posedge clk);
    #2 RST = 1'b1;
    #1;
    chk("rst_mid_C", {C00, C01, C10, C11}, 16'h0);
    chk("rst_mid_flags", {busy, valid, err}, 3'b000);
`ifdef GFMM_PARITY_EN
    chk("rst_mid_Cpar", Cpar, 1'b0);
`endif
    exp_q.delete();
    v0 = valid_cnt;
    repeat (2) @(negedge clk);
    RST = 1'b0;
    repeat (12) @(negedge clk);
    chk("rst_no_valid", valid_cnt - v0, 0);

    start(16'hBEEF, 16'hCAFE, matmul(16'hBEEF, 16'hCAFE));
    run_tail("post_rst", 10'h000, 1'b0);

    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
